// File: rtl/result_display_if.sv
// result_display_if: valid/ready handshake carrying a 5-bit sign-magnitude result
// res_valid: source has a result; res_data: {sign, mag[3:0]}; res_ready: sink can accept
// master = upstream adder stage, slave = result_display
interface result_display_if;
    logic       res_valid;
    logic [4:0] res_data;
    logic       res_ready;
    modport master (output res_valid, output res_data, input res_ready);
    modport slave (input res_valid, input res_data, output res_ready);
endinterface

// File: rtl/result_display.sv
// result_display: frame-synchronous two-digit active-low 7-segment display of a sign-magnitude result
// clk/rst_n: clock, synchronous active-low reset; res: result handshake (slave)
// seg_n {g,f,e,d,c,b,a} and an_n (bit1 sign, bit0 magnitude) active low; err: committed value illegal
module result_display #(
    parameter int REFRESH_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    result_display_if.slave     res,
    output logic [6:0]          seg_n,
    output logic [1:0]          an_n,
    output logic                err
);
    localparam int CW = $clog2(REFRESH_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_CYCLES - 1);
    typedef enum logic [1:0] {BLANK, SIGN, MAG} state_t;
    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          full, full_d, ready_q, accept, commit, bad, neg;
    logic [4:0]    pend, disp;
    logic [6:0]    seg_d;
    logic [1:0]    an_d;
    function automatic logic [6:0] glyph(input logic [2:0] m);
        case (m)
            3'd0:    glyph = 7'h40;
            3'd1:    glyph = 7'h79;
            3'd2:    glyph = 7'h24;
            3'd3:    glyph = 7'h30;
            3'd4:    glyph = 7'h19;
            3'd5:    glyph = 7'h12;
            3'd6:    glyph = 7'h02;
            default: glyph = 7'h7F;
        endcase
    endfunction
    assign res.res_ready = ready_q;
    assign accept = res.res_valid & ready_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= BLANK;
            cnt     <= '0;
            full    <= 1'b0;
            ready_q <= 1'b1;
            pend    <= '0;
            disp    <= '0;
            seg_n   <= 7'h7F;
            an_n    <= 2'b11;
            err     <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            full    <= full_d;
            ready_q <= ~full_d;
            if (accept) pend <= res.res_data;
            if (commit) disp <= pend;
            seg_n   <= seg_d;
            an_n    <= an_d;
            err     <= bad;
        end
    end
    // Commits happen only when leaving BLANK or on the MAG->SIGN frame boundary.
    always_comb begin
        state_d = state;
        cnt_d   = cnt + 1'b1;
        commit  = 1'b0;
        case (state)
            BLANK: begin
                cnt_d = '0;
                if (full) begin
                    commit  = 1'b1;
                    state_d = SIGN;
                end
            end
            SIGN: if (cnt == LAST) begin
                state_d = MAG;
                cnt_d   = '0;
            end
            MAG: if (cnt == LAST) begin
                state_d = SIGN;
                cnt_d   = '0;
                commit  = full;
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
        full_d = accept ? 1'b1 : commit ? 1'b0 : full;
    end
    // Negative zero and errors both suppress the minus sign.
    always_comb begin
        bad   = disp[3:0] > 4'd6;
        neg   = disp[4] & ~bad & (disp[3:0] != 4'd0);
        seg_d = state == SIGN ? (neg ? 7'h3F : 7'h7F)
              : state == MAG  ? (bad ? 7'h06 : glyph(disp[2:0]))
              : 7'h7F;
        an_d  = state == SIGN ? 2'b01 : state == MAG ? 2'b10 : 2'b11;
    end
endmodule

// File: tb/tb_result_display.sv
// tb_result_display: directed table-driven checks of result_display with REFRESH_CYCLES=4
module tb_result_display;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_n;
    logic [1:0] an_n;
    logic       err;
    int         passes = 0;
    int         checks = 0;
    int         t = 0;
    typedef struct {
        logic [4:0] data;
        logic [6:0] sseg;
        logic [6:0] mseg;
        logic       e;
    } vec_t;
    vec_t vecs[7];
    result_display_if rif();
    result_display #(.REFRESH_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .res(rif), .seg_n(seg_n), .an_n(an_n), .err(err)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
        t++;
    endtask
    task automatic tick_to(input int n);
        while (t < n) tick();
    endtask
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask
    task automatic do_reset;
        rst_n = 1'b0;
        rif.res_valid = 1'b0;
        rif.res_data = 5'd0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask
    task automatic send(input logic [4:0] d);
        rif.res_valid = 1'b1;
        rif.res_data = d;
        tick();
        rif.res_valid = 1'b0;
        t = 0;
    endtask
    initial begin
        vecs[0] = '{5'b00011, 7'h7F, 7'h30, 1'b0};
        vecs[1] = '{5'b10101, 7'h3F, 7'h12, 1'b0};
        vecs[2] = '{5'b10000, 7'h7F, 7'h40, 1'b0};
        vecs[3] = '{5'b01000, 7'h7F, 7'h06, 1'b1};
        vecs[4] = '{5'b00000, 7'h7F, 7'h40, 1'b0};
        vecs[5] = '{5'b10110, 7'h3F, 7'h02, 1'b0};
        vecs[6] = '{5'b11111, 7'h7F, 7'h06, 1'b1};
        rif.res_valid = 1'b0;
        rif.res_data = 5'd0;
        do_reset();
        chk("rst_ready", 8'(rif.res_ready), 8'h1);
        chk("rst_seg", 8'(seg_n), 8'h7F);
        chk("rst_an", 8'(an_n), 8'h3);
        chk("rst_err", 8'(err), 8'h0);
        repeat (10) tick();
        chk("idle_an", 8'(an_n), 8'h3);
        chk("idle_seg", 8'(seg_n), 8'h7F);
        for (int i = 0; i < 7; i++) begin
            do_reset();
            send(vecs[i].data);
            chk($sformatf("v%0d_ready_low", i), 8'(rif.res_ready), 8'h0);
            tick();
            chk($sformatf("v%0d_still_blank", i), 8'(an_n), 8'h3);
            chk($sformatf("v%0d_ready_high", i), 8'(rif.res_ready), 8'h1);
            tick_to(2);
            for (int k = 0; k <= 8; k++) begin
                chk($sformatf("v%0d_an_k%0d", i, k), 8'(an_n), (k >= 4 && k < 8) ? 8'h2 : 8'h1);
                chk($sformatf("v%0d_seg_k%0d", i, k), 8'(seg_n),
                    8'((k >= 4 && k < 8) ? vecs[i].mseg : vecs[i].sseg));
                chk($sformatf("v%0d_err_k%0d", i, k), 8'(err), 8'(vecs[i].e));
                tick();
            end
        end
        // error value replaced by a legal one at the next frame boundary
        do_reset();
        send(5'b01000);
        tick_to(2);
        rif.res_valid = 1'b1;
        rif.res_data = 5'b00110;
        tick();
        rif.res_valid = 1'b0;
        chk("errseq_ready_low", 8'(rif.res_ready), 8'h0);
        tick_to(6);
        chk("errseq_mag_e", 8'(seg_n), 8'h06);
        chk("errseq_an_mag", 8'(an_n), 8'h2);
        chk("errseq_err_hi", 8'(err), 8'h1);
        tick_to(9);
        chk("errseq_err_before_boundary", 8'(err), 8'h1);
        tick_to(10);
        chk("errseq_err_cleared", 8'(err), 8'h0);
        tick_to(14);
        chk("errseq_new_mag", 8'(seg_n), 8'h02);
        chk("errseq_new_an", 8'(an_n), 8'h2);
        // back-pressure: second value held until the first commits
        do_reset();
        send(5'b00011);
        tick_to(2);
        rif.res_valid = 1'b1;
        rif.res_data = 5'b00001;
        tick();
        rif.res_data = 5'b00010;
        chk("bp_ready_low_t3", 8'(rif.res_ready), 8'h0);
        tick_to(6);
        chk("bp_old_mag", 8'(seg_n), 8'h30);
        tick_to(8);
        chk("bp_ready_low_t8", 8'(rif.res_ready), 8'h0);
        tick_to(9);
        chk("bp_ready_high_t9", 8'(rif.res_ready), 8'h1);
        tick_to(10);
        rif.res_valid = 1'b0;
        chk("bp_ready_low_t10", 8'(rif.res_ready), 8'h0);
        tick_to(14);
        chk("bp_first_mag", 8'(seg_n), 8'h79);
        chk("bp_first_an", 8'(an_n), 8'h2);
        tick_to(16);
        chk("bp_ready_low_t16", 8'(rif.res_ready), 8'h0);
        tick_to(17);
        chk("bp_ready_high_t17", 8'(rif.res_ready), 8'h1);
        chk("bp_first_mag_last", 8'(seg_n), 8'h79);
        tick_to(22);
        chk("bp_second_mag", 8'(seg_n), 8'h24);
        tick_to(30);
        chk("bp_second_stable", 8'(seg_n), 8'h24);
        chk("bp_second_stable_an", 8'(an_n), 8'h2);
        // reset during MAG with a value pending
        do_reset();
        send(5'b00011);
        tick_to(5);
        rif.res_valid = 1'b1;
        rif.res_data = 5'b00101;
        tick();
        rif.res_valid = 1'b0;
        chk("mr_pending_full", 8'(rif.res_ready), 8'h0);
        rst_n = 1'b0;
        tick();
        chk("mr_an", 8'(an_n), 8'h3);
        chk("mr_seg", 8'(seg_n), 8'h7F);
        chk("mr_ready", 8'(rif.res_ready), 8'h1);
        chk("mr_err", 8'(err), 8'h0);
        rst_n = 1'b1;
        tick_to(20);
        chk("mr_stays_blank", 8'(an_n), 8'h3);
        tick_to(28);
        chk("mr_stays_blank_late", 8'(an_n), 8'h3);
        chk("mr_seg_blank_late", 8'(seg_n), 8'h7F);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
